// File: rtl/led_breath_pwm.sv
// PWM dimmer for the led pattern generator. It supports direct pass-through, fixed duty,
// triangular "breathing" with holds, and all-off. Mode and duty take effect only at PWM period boundaries.
module led_breath_pwm #(
    parameter int N_LED        = 4,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE     = 4,
    parameter int STEP_PERIODS = 2,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LED-1:0]    led_in,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_LED-1:0]    led_out,
    output logic [PWM_BITS-1:0] breath_level,
    output logic                pwm_sync
);

    localparam int PRE_W  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_DOWN    = 2'd2,
        ST_HOLD_LO = 2'd3
    } breath_state_t;

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [1:0]          mode_eff_r;
    logic [PWM_BITS-1:0] duty_eff_r;
    logic [STEP_W-1:0]   step_cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    breath_state_t       state_r;

    logic                pre_last_s;
    logic                period_end_s;
    logic [PWM_BITS-1:0] lvl_s;
    logic                on_s;
    logic [N_LED-1:0]    led_next_s;

    // Period boundary detection, brightness selection and next LED drive
    always_comb begin
        pre_last_s   = (pre_cnt_r == PRE_LAST);
        period_end_s = pre_last_s && (pwm_cnt_r == LVL_MAX);
        case (mode_eff_r)
            2'd1:    lvl_s = duty_eff_r;
            2'd2:    lvl_s = breath_level;
            default: lvl_s = LVL_ZERO;
        endcase
        on_s = (pwm_cnt_r < lvl_s);
        case (mode_eff_r)
            2'd0:       led_next_s = led_in;
            2'd1, 2'd2: led_next_s = led_in & {N_LED{on_s}};
            default:    led_next_s = {N_LED{1'b0}};
        endcase
    end

    // Prescaler, PWM counter and period-start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            pwm_cnt_r <= LVL_ZERO;
            pwm_sync  <= 1'b0;
        end else begin
            pwm_sync <= period_end_s;
            if (pre_last_s) begin
                pre_cnt_r <= {PRE_W{1'b0}};
                pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
            end else begin
                pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            end
        end
    end

    // Boundary-latched mode/duty and the registered LED drive (led_in itself is never latched)
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_eff_r <= 2'd0;
            duty_eff_r <= LVL_ZERO;
            led_out    <= {N_LED{1'b0}};
        end else begin
            led_out <= led_next_s;
            if (period_end_s) begin
                mode_eff_r <= mode;
                duty_eff_r <= duty;
            end
        end
    end

    // Breath envelope FSM; it steps on the old mode_eff when a boundary also latches a new mode
    always_ff @(posedge clk) begin
        if (rst || (mode_eff_r != 2'd2)) begin
            state_r      <= ST_UP;
            breath_level <= LVL_ZERO;
            step_cnt_r   <= {STEP_W{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
        end else if (period_end_s) begin
            case (state_r)
                ST_UP: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_r <= {STEP_W{1'b0}};
                        if (breath_level != LVL_MAX) begin
                            breath_level <= breath_level + LVL_ONE;
                            if (breath_level == (LVL_MAX - LVL_ONE)) state_r <= ST_HOLD_HI;
                        end else begin
                            state_r <= ST_HOLD_HI;
                        end
                    end else begin
                        step_cnt_r <= step_cnt_r + STEP_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (step_cnt_r == STEP_LAST) begin
                        step_cnt_r <= {STEP_W{1'b0}};
                        if (breath_level != LVL_ZERO) begin
                            breath_level <= breath_level - LVL_ONE;
                            if (breath_level == LVL_ONE) state_r <= ST_HOLD_LO;
                        end else begin
                            state_r <= ST_HOLD_LO;
                        end
                    end else begin
                        step_cnt_r <= step_cnt_r + STEP_W'(1);
                    end
                end
                ST_HOLD_HI, ST_HOLD_LO: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        state_r    <= (state_r == ST_HOLD_HI) ? ST_DOWN : ST_UP;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_UP;
                    breath_level <= LVL_ZERO;
                    step_cnt_r   <= {STEP_W{1'b0}};
                    hold_cnt_r   <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Randomized scoreboard bench for led_breath_pwm. Expectations come from a time-based model:
// PWM position from the cycle count, and breath level from a closed-form envelope of periods spent breathing.
module tb_led_breath_pwm;

    localparam int PS   = 1;
    localparam int SP   = 1;
    localparam int HP   = 2;
    localparam int MAXL = 15;
    localparam int PER  = PS * 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_in;
    logic [1:0] mode;
    logic [3:0] duty;
    logic [3:0] led_out;
    logic [3:0] breath_level;
    logic       pwm_sync;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] lvl;
        logic       sync;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   checks = 0;
    int   errors = 0;

    // model state: cycles since reset release, latched mode/duty, periods spent breathing
    int cyc, m_mode, m_duty, bk;

    led_breath_pwm #(
        .N_LED(4), .PWM_BITS(4), .PRESCALE(PS), .STEP_PERIODS(SP), .HOLD_PERIODS(HP)
    ) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .mode(mode), .duty(duty),
        .led_out(led_out), .breath_level(breath_level), .pwm_sync(pwm_sync)
    );

    always #5 clk = ~clk;

    // Envelope level during the k-th breathing period: ramp up, hold high, ramp down, hold low
    function automatic int env(input int k);
        int p;
        p = k % (2 * MAXL * SP + 2 * HP);
        if (p < MAXL * SP) return p / SP;
        p = p - MAXL * SP;
        if (p < HP) return MAXL;
        p = p - HP;
        if (p < MAXL * SP) return MAXL - p / SP;
        return 0;
    endfunction

    task automatic step(input logic r, input logic [3:0] li, input logic [1:0] md, input logic [3:0] dt);
        exp_t e;
        int   pwm, lvl, old_mode;
        bit   pend;
        @(negedge clk);
        rst = r; led_in = li; mode = md; duty = dt;
        if (r) begin
            e = '0;
            cyc = 0; m_mode = 0; m_duty = 0; bk = 0;
        end else begin
            pwm  = (cyc / PS) % 16;
            pend = ((cyc % PER) == PER - 1);
            lvl  = (m_mode == 1) ? m_duty : (m_mode == 2) ? env(bk) : 0;
            case (m_mode)
                0:       e.led = li;
                3:       e.led = 4'h0;
                default: e.led = (pwm < lvl) ? li : 4'h0;
            endcase
            e.sync = pend;
            e.lvl  = (m_mode == 2) ? 4'(env(pend ? bk + 1 : bk)) : 4'h0;
            old_mode = m_mode;
            if (old_mode != 2) bk = 0;
            else if (pend) bk = bk + 1;
            if (pend) begin
                m_mode = int'(md);
                m_duty = int'(dt);
            end
            cyc = cyc + 1;
        end
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per clock and compares it with the registered outputs
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            checks = checks + 3;
            if (led_out !== got_e.led) begin
                errors = errors + 1;
                $display("FAIL led_out @%0t: got %h expected %h", $time, led_out, got_e.led);
            end
            if (breath_level !== got_e.lvl) begin
                errors = errors + 1;
                $display("FAIL breath_level @%0t: got %0d expected %0d", $time, breath_level, got_e.lvl);
            end
            if (pwm_sync !== got_e.sync) begin
                errors = errors + 1;
                $display("FAIL pwm_sync @%0t: got %b expected %b", $time, pwm_sync, got_e.sync);
            end
        end
    end

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    initial begin
        logic [3:0] d;
        logic [1:0] md;
        rst = 1'b1; led_in = 4'h0; mode = 2'd0; duty = 4'h0;

        repeat (3) step(1'b1, rnd4(), 2'd0, 4'h0);

        // direct pass-through with led_in changing every clock
        repeat (40) step(1'b0, rnd4(), 2'd0, rnd4());

        // fixed duty including 0, MAX and a 4->12 switch mid-period
        for (int k = 0; k < 8; k++) begin
            d = (k == 0) ? 4'd0 : (k == 1) ? 4'd15 : (k == 2) ? 4'd4 : rnd4();
            for (int i = 0; i < 2 * PER; i++) begin
                if (i == 6) d = (k == 2) ? 4'd12 : rnd4();
                step(1'b0, (k < 3) ? 4'hF : rnd4(), 2'd1, d);
            end
        end

        repeat (2 * PER) step(1'b0, rnd4(), 2'd3, rnd4());

        // more than one full breath cycle
        repeat (600) step(1'b0, ($urandom_range(0, 7) == 0) ? rnd4() : 4'hF, 2'd2, rnd4());

        // leave breathing mid-ramp, then re-enter and leave again
        repeat (PER) step(1'b0, 4'hF, 2'd1, 4'd7);
        repeat (10 * PER + $urandom_range(0, 15)) step(1'b0, 4'hF, 2'd2, 4'd5);
        repeat (3 * PER) step(1'b0, 4'hF, 2'd1, 4'd5);

        // reset held for five clocks in the middle of a breath
        repeat (PER * 20 + 7) step(1'b0, 4'hF, 2'd2, rnd4());
        repeat (5) step(1'b1, 4'hF, 2'd2, rnd4());
        repeat (PER * 40) step(1'b0, 4'hF, 2'd2, rnd4());

        // random mode/duty changes at random times
        repeat (20) begin
            md = 2'($urandom);
            d  = rnd4();
            repeat ($urandom_range(5, 100)) step(1'b0, rnd4(), md, d);
        end

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
